// File: rtl/video_source_gen_if.sv
// Video source bus: clock enable and flat colour into the generator,
// timing flags and the two 20-bit {luma, chroma} streams out of it.
interface video_source_gen_if;
  logic        cen_i;
  logic [29:0] colour_i;
  logic [3:0]  fvht_o;
  logic [19:0] vdat_bars_o;
  logic [19:0] vdat_colour_o;

  modport master (
    input  cen_i,
    input  colour_i,
    output fvht_o,
    output vdat_bars_o,
    output vdat_colour_o
  );

  modport slave (
    output cen_i,
    output colour_i,
    input  fvht_o,
    input  vdat_bars_o,
    input  vdat_colour_o
  );
endinterface

// File: rtl/video_source_gen.sv
// 1080p-style 4:2:2 video source: line/frame position counters, embedded
// EAV/SAV timing reference words, 75% colour bars and a flat-colour stream.
module video_source_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int V_BLANK  = 45,
  parameter int V_TOTAL  = 1125,
  parameter int BAR_W    = 240
) (
  input  logic               clk_i,
  input  logic               rst_i,
  video_source_gen_if.master vid
);

  localparam logic [11:0] HT_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] VT_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] HB        = 12'(H_TOTAL - H_ACTIVE);
  localparam logic [11:0] SAV_START = 12'(H_TOTAL - H_ACTIVE - 4);
  localparam logic [11:0] VB        = 12'(V_BLANK);
  localparam logic [11:0] BW        = 12'(BAR_W);
  localparam logic [9:0]  Y_BLANK   = 10'h040;
  localparam logic [9:0]  C_BLANK   = 10'h200;
  localparam logic        F_BIT     = 1'b0;

  typedef enum logic [1:0] {REG_EAV, REG_HBLANK, REG_SAV, REG_ACTIVE} region_t;

  logic [11:0] hc, vc, hc_n, vc_n, x, bar_full;
  logic [29:0] colour_q;
  logic [3:0]  fvht_q, fvht_n;
  logic [19:0] bars_q, bars_n, col_q, col_n;
  logic        wrap_h, v_n, h_n, h_trs, frame_start;
  region_t     region;
  logic [1:0]  trs_idx;
  logic [9:0]  xyz, trs_word, bar_y, bar_cb, bar_cr;
  logic [2:0]  bar_idx;

  // Next position and the sample that belongs to it; registered below so
  // the outputs for a position appear in the cycle the counters reach it.
  always_comb begin
    wrap_h      = (hc == HT_LAST);
    hc_n        = wrap_h ? '0 : hc + 12'd1;
    vc_n        = vc;
    if (wrap_h) vc_n = (vc == VT_LAST) ? '0 : vc + 12'd1;
    frame_start = (hc_n == '0) && (vc_n == '0);
    v_n         = (vc_n < VB);
    h_n         = (hc_n < HB);

    if (hc_n < 12'd4)          region = REG_EAV;
    else if (hc_n < SAV_START) region = REG_HBLANK;
    else if (hc_n < HB)        region = REG_SAV;
    else                       region = REG_ACTIVE;

    h_trs   = (region == REG_EAV);
    trs_idx = (region == REG_EAV) ? hc_n[1:0] : 2'(hc_n - SAV_START);
    xyz     = {1'b1, F_BIT, v_n, h_trs, v_n ^ h_trs, F_BIT ^ h_trs,
               F_BIT ^ v_n, F_BIT ^ v_n ^ h_trs, 2'b00};
    case (trs_idx)
      2'd0:    trs_word = 10'h3FF;
      2'd3:    trs_word = xyz;
      default: trs_word = '0;
    endcase

    x        = hc_n - HB;
    bar_full = x / BW;
    bar_idx  = (bar_full > 12'd7) ? 3'd7 : bar_full[2:0];
    case (bar_idx)
      3'd0:    {bar_y, bar_cb, bar_cr} = {10'd721, 10'd512, 10'd512};
      3'd1:    {bar_y, bar_cb, bar_cr} = {10'd646, 10'd176, 10'd554};
      3'd2:    {bar_y, bar_cb, bar_cr} = {10'd525, 10'd625, 10'd176};
      3'd3:    {bar_y, bar_cb, bar_cr} = {10'd450, 10'd289, 10'd218};
      3'd4:    {bar_y, bar_cb, bar_cr} = {10'd335, 10'd735, 10'd806};
      3'd5:    {bar_y, bar_cb, bar_cr} = {10'd260, 10'd399, 10'd848};
      3'd6:    {bar_y, bar_cb, bar_cr} = {10'd139, 10'd848, 10'd470};
      default: {bar_y, bar_cb, bar_cr} = {10'd64,  10'd512, 10'd512};
    endcase

    fvht_n = {F_BIT, v_n, h_n, 1'b0};
    bars_n = {Y_BLANK, C_BLANK};
    col_n  = {Y_BLANK, C_BLANK};
    unique case (region)
      REG_EAV, REG_SAV: begin
        fvht_n[0] = 1'b1;
        bars_n    = {trs_word, trs_word};
        col_n     = {trs_word, trs_word};
      end
      REG_HBLANK: ;
      REG_ACTIVE: begin
        if (!v_n) begin
          bars_n = {bar_y, x[0] ? bar_cr : bar_cb};
          col_n  = {colour_q[29:20], x[0] ? colour_q[9:0] : colour_q[19:10]};
        end
      end
    endcase
  end

  // Position counters, frame-latched colour and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc       <= HT_LAST;
      vc       <= VT_LAST;
      colour_q <= {Y_BLANK, C_BLANK, C_BLANK};
      fvht_q   <= 4'b0110;
      bars_q   <= {Y_BLANK, C_BLANK};
      col_q    <= {Y_BLANK, C_BLANK};
    end else if (vid.cen_i) begin
      hc     <= hc_n;
      vc     <= vc_n;
      fvht_q <= fvht_n;
      bars_q <= bars_n;
      col_q  <= col_n;
      if (frame_start) colour_q <= vid.colour_i;
    end
  end

  assign vid.fvht_o        = fvht_q;
  assign vid.vdat_bars_o   = bars_q;
  assign vid.vdat_colour_o = col_q;

endmodule

// File: tb/tb_video_source_gen.sv
// Directed bench: a default-size instance for the first line of a frame and
// a scaled-down instance (48x8 samples, 3-sample bars) for frame-level checks.
module tb_video_source_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  int   se     = 0;   // enabled edges of the small instance since reset

  always #5 clk = ~clk;

  video_source_gen_if vs();
  video_source_gen_if vd();

  video_source_gen #(.H_ACTIVE(32), .H_TOTAL(48), .V_BLANK(3), .V_TOTAL(8), .BAR_W(3))
    dut_s (.clk_i(clk), .rst_i(rst), .vid(vs));
  video_source_gen dut_d (.clk_i(clk), .rst_i(rst), .vid(vd));

  // advance the small instance so its outputs show linear position p
  task automatic goto_s(input int p);
    vs.cen_i = 1'b1;
    repeat (p + 1 - se) begin @(posedge clk); #1; end
    se = p + 1;
    vs.cen_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (vs.fvht_o !== 4'b0110) begin fails++; $display("FAIL rst_s_fvht: got %b want 0110", vs.fvht_o); end
    checks++; if (vs.vdat_bars_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL rst_s_bars: got %h want 10200", vs.vdat_bars_o); end
    checks++; if (vs.vdat_colour_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL rst_s_col: got %h want 10200", vs.vdat_colour_o); end
    checks++; if (vd.fvht_o !== 4'b0110) begin fails++; $display("FAIL rst_d_fvht: got %b want 0110", vd.fvht_o); end
    checks++; if (vd.vdat_bars_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL rst_d_bars: got %h want 10200", vd.vdat_bars_o); end
    checks++; if (vd.vdat_colour_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL rst_d_col: got %h want 10200", vd.vdat_colour_o); end
    rst = 1'b0;
  endtask

  // default geometry: EAV at hc 0..3, SAV at 276..279, first active at 280
  task automatic test_default_line0();
    logic [9:0]  w;
    logic [19:0] e;
    vd.cen_i = 1'b1;
    for (int n = 1; n <= 281; n++) begin
      @(posedge clk); #1;
      if (n <= 4 || (n >= 277 && n <= 280)) begin
        w = (n == 1 || n == 277) ? 10'h3FF : (n == 4) ? 10'h2D8 : (n == 280) ? 10'h2AC : 10'h000;
        e = {w, w};
        checks++; if (vd.fvht_o !== 4'b0111) begin fails++; $display("FAIL d_trs_fvht n=%0d: got %b want 0111", n, vd.fvht_o); end
        checks++; if (vd.vdat_bars_o !== e) begin fails++; $display("FAIL d_trs_bars n=%0d: got %h want %h", n, vd.vdat_bars_o, e); end
        checks++; if (vd.vdat_colour_o !== e) begin fails++; $display("FAIL d_trs_col n=%0d: got %h want %h", n, vd.vdat_colour_o, e); end
      end else if (n == 5 || n == 281) begin
        checks++; if (vd.fvht_o !== ((n == 5) ? 4'b0110 : 4'b0100)) begin fails++; $display("FAIL d_blank_fvht n=%0d: got %b", n, vd.fvht_o); end
        checks++; if (vd.vdat_bars_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL d_blank_bars n=%0d: got %h want 10200", n, vd.vdat_bars_o); end
      end
    end
    vd.cen_i = 1'b0;
    checks++; if (vs.fvht_o !== 4'b0110 || vs.vdat_bars_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL s_hold_no_cen: got %b/%h want 0110/10200", vs.fvht_o, vs.vdat_bars_o); end
  endtask

  task automatic test_blank_lines();
    goto_s(3);
    checks++; if (vs.vdat_bars_o !== {10'h2D8, 10'h2D8}) begin fails++; $display("FAIL s_eav_l0: got %h want b62d8", vs.vdat_bars_o); end
    goto_s(15);
    checks++; if (vs.vdat_bars_o !== {10'h2AC, 10'h2AC}) begin fails++; $display("FAIL s_sav_l0: got %h want ab2ac", vs.vdat_bars_o); end
    checks++; if (vs.fvht_o !== 4'b0111) begin fails++; $display("FAIL s_sav_l0_fvht: got %b want 0111", vs.fvht_o); end
    goto_s(112);
    checks++; if (vs.fvht_o !== 4'b0100) begin fails++; $display("FAIL s_l2_act_fvht: got %b want 0100", vs.fvht_o); end
    checks++; if (vs.vdat_bars_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL s_l2_act_bars: got %h want 10200", vs.vdat_bars_o); end
  endtask

  task automatic test_active_line();
    goto_s(147);
    checks++; if (vs.fvht_o !== 4'b0011) begin fails++; $display("FAIL s_l3_eav_fvht: got %b want 0011", vs.fvht_o); end
    checks++; if (vs.vdat_colour_o !== {10'h274, 10'h274}) begin fails++; $display("FAIL s_l3_eav: got %h want 9d274", vs.vdat_colour_o); end
    goto_s(159);
    checks++; if (vs.vdat_bars_o !== {10'h200, 10'h200}) begin fails++; $display("FAIL s_l3_sav: got %h want 80200", vs.vdat_bars_o); end
    goto_s(160);
    checks++; if (vs.fvht_o !== 4'b0000) begin fails++; $display("FAIL s_l3_first_fvht: got %b want 0000", vs.fvht_o); end
    checks++; if (vs.vdat_bars_o !== {10'h2D1, 10'h200}) begin fails++; $display("FAIL s_white_cb: got %h want b4600", vs.vdat_bars_o); end
    checks++; if (vs.vdat_colour_o !== {10'h1A0, 10'h150}) begin fails++; $display("FAIL s_col_cb: got %h want 68150", vs.vdat_colour_o); end
    goto_s(161);
    checks++; if (vs.vdat_bars_o !== {10'h2D1, 10'h200}) begin fails++; $display("FAIL s_white_cr: got %h want b4600", vs.vdat_bars_o); end
    checks++; if (vs.vdat_colour_o !== {10'h1A0, 10'h2E0}) begin fails++; $display("FAIL s_col_cr: got %h want 682e0", vs.vdat_colour_o); end
    goto_s(163);
    checks++; if (vs.vdat_bars_o !== {10'h286, 10'h22A}) begin fails++; $display("FAIL s_yellow_cr: got %h want a1a2a", vs.vdat_bars_o); end
    goto_s(164);
    checks++; if (vs.vdat_bars_o !== {10'h286, 10'h0B0}) begin fails++; $display("FAIL s_yellow_cb: got %h want a18b0", vs.vdat_bars_o); end
    goto_s(180);
    checks++; if (vs.vdat_bars_o !== {10'h08B, 10'h350}) begin fails++; $display("FAIL s_blue_cb: got %h want 22f50", vs.vdat_bars_o); end
    goto_s(181);
    checks++; if (vs.vdat_bars_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL s_black_cr: got %h want 10200", vs.vdat_bars_o); end
    goto_s(184);
    checks++; if (vs.vdat_bars_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL s_bar_clamp: got %h want 10200", vs.vdat_bars_o); end
  endtask

  task automatic test_colour_latch();
    vs.colour_i = {10'h3FC, 10'h0B0, 10'h21F};
    goto_s(260);
    checks++; if (vs.vdat_colour_o !== {10'h1A0, 10'h150}) begin fails++; $display("FAIL s_col_old_frame: got %h want 68150", vs.vdat_colour_o); end
    goto_s(384);
    checks++; if (vs.fvht_o !== 4'b0111 || vs.vdat_bars_o !== {10'h3FF, 10'h3FF}) begin fails++; $display("FAIL s_frame_wrap: got %b/%h want 0111/fffff", vs.fvht_o, vs.vdat_bars_o); end
    goto_s(544);
    checks++; if (vs.vdat_colour_o !== {10'h3FC, 10'h0B0}) begin fails++; $display("FAIL s_col_new_cb: got %h want ff0b0", vs.vdat_colour_o); end
    goto_s(545);
    checks++; if (vs.vdat_colour_o !== {10'h3FC, 10'h21F}) begin fails++; $display("FAIL s_col_new_cr: got %h want ff21f", vs.vdat_colour_o); end
  endtask

  task automatic test_cen_gap();
    goto_s(601);
    checks++; if (vs.vdat_bars_o !== {10'h1C2, 10'h0DA}) begin fails++; $display("FAIL s_green_cr: got %h want 708da", vs.vdat_bars_o); end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (vs.vdat_bars_o !== {10'h1C2, 10'h0DA} || vs.fvht_o !== 4'b0000) begin fails++; $display("FAIL s_gap_hold: got %b/%h want 0000/708da", vs.fvht_o, vs.vdat_bars_o); end
    checks++; if (vs.vdat_colour_o !== {10'h3FC, 10'h21F}) begin fails++; $display("FAIL s_gap_hold_col: got %h want ff21f", vs.vdat_colour_o); end
    goto_s(602);
    checks++; if (vs.vdat_bars_o !== {10'h1C2, 10'h121}) begin fails++; $display("FAIL s_gap_resume: got %h want 70921", vs.vdat_bars_o); end
    checks++; if (vs.vdat_colour_o !== {10'h3FC, 10'h0B0}) begin fails++; $display("FAIL s_gap_resume_col: got %h want ff0b0", vs.vdat_colour_o); end
  endtask

  task automatic test_v_period();
    int   cnt, fall;
    logic prev, found;
    vs.cen_i = 1'b1;
    cnt = 0; found = 1'b0; prev = vs.fvht_o[2];
    while (!found && cnt < 1000) begin
      @(posedge clk); #1; cnt++;
      if (!prev && vs.fvht_o[2]) found = 1'b1;
      prev = vs.fvht_o[2];
    end
    checks++; if (!found) begin fails++; $display("FAIL s_v_first_rise: got none in %0d cycles want a rise", cnt); end
    cnt = 0; fall = 0; found = 1'b0;
    while (!found && cnt < 1000) begin
      @(posedge clk); #1; cnt++;
      if (prev && !vs.fvht_o[2]) fall = cnt;
      if (!prev && vs.fvht_o[2]) found = 1'b1;
      prev = vs.fvht_o[2];
    end
    vs.cen_i = 1'b0;
    checks++; if (!found || cnt != 384) begin fails++; $display("FAIL s_v_period: got %0d want 384", cnt); end
    checks++; if (fall != 144) begin fails++; $display("FAIL s_v_fall: got %0d want 144", fall); end
  endtask

  task automatic test_mid_reset();
    vs.cen_i = 1'b1;
    repeat (170) begin @(posedge clk); #1; end
    vs.cen_i = 1'b0;
    checks++; if (vs.vdat_bars_o !== {10'h1C2, 10'h121}) begin fails++; $display("FAIL s_pre_rst: got %h want 70921", vs.vdat_bars_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if (vs.fvht_o !== 4'b0110) begin fails++; $display("FAIL s_async_rst_fvht: got %b want 0110", vs.fvht_o); end
    checks++; if (vs.vdat_bars_o !== {10'h040, 10'h200} || vs.vdat_colour_o !== {10'h040, 10'h200}) begin fails++; $display("FAIL s_async_rst_vid: got %h/%h want 10200", vs.vdat_bars_o, vs.vdat_colour_o); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vs.cen_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (vs.fvht_o !== 4'b0111 || vs.vdat_bars_o !== {10'h3FF, 10'h3FF}) begin fails++; $display("FAIL s_post_rst_eav0: got %b/%h want 0111/fffff", vs.fvht_o, vs.vdat_bars_o); end
    repeat (3) begin @(posedge clk); #1; end
    vs.cen_i = 1'b0;
    checks++; if (vs.vdat_colour_o !== {10'h2D8, 10'h2D8}) begin fails++; $display("FAIL s_post_rst_eav3: got %h want b62d8", vs.vdat_colour_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vs.cen_i    = 1'b0;
    vs.colour_i = {10'h1A0, 10'h150, 10'h2E0};
    vd.cen_i    = 1'b0;
    vd.colour_i = '0;
    test_reset();
    test_default_line0();
    test_blank_lines();
    test_active_line();
    test_colour_latch();
    test_cen_gap();
    test_v_period();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
